// File: rtl/pad_input_filter.sv
// pad_input_filter: synchronises, debounces and edge-detects raw pad inputs
// ahead of pad_control. Each pin has a two-flop synchroniser, a tick-driven
// stability counter (or a bypass path), registered rise/fall pulses and a
// sticky event flag. The interrupt is the masked OR of the event flags.
module pad_input_filter #(
    parameter int N_PINS  = 32,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_PINS-1:0]  pad_in_i,
    input  logic [N_PINS-1:0]  filt_en_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic [CNT_W-1:0]   thresh_i,
    input  logic [N_PINS-1:0]  irq_mask_i,
    input  logic [N_PINS-1:0]  evt_clr_i,
    output logic [N_PINS-1:0]  filt_o,
    output logic [N_PINS-1:0]  rise_o,
    output logic [N_PINS-1:0]  fall_o,
    output logic [N_PINS-1:0]  evt_o,
    output logic               irq_o
);

    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]     CNT_ONE_X  = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] PC_ZERO    = {PRESC_W{1'b0}};
    localparam logic [PRESC_W-1:0] PC_ONE     = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic [N_PINS-1:0]  PINS_ZERO  = {N_PINS{1'b0}};

    logic [N_PINS-1:0]  s1_r;
    logic [N_PINS-1:0]  s2_r;
    logic [PRESC_W-1:0] pc_r;
    logic [PRESC_W-1:0] pc_next_s;
    logic               tick_s;
    logic [CNT_W-1:0]   thr_s;
    logic [CNT_W-1:0]   cnt_r      [N_PINS];
    logic [CNT_W-1:0]   cnt_next_s [N_PINS];
    logic [CNT_W:0]     cnt_inc_s  [N_PINS];
    logic [N_PINS-1:0]  filt_r;
    logic [N_PINS-1:0]  filt_next_s;
    logic [N_PINS-1:0]  rise_r;
    logic [N_PINS-1:0]  fall_r;
    logic [N_PINS-1:0]  evt_r;

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_r <= PINS_ZERO;
            s2_r <= PINS_ZERO;
        end else begin
            s1_r <= pad_in_i;
            s2_r <= s1_r;
        end
    end

    // Prescaler tick; the >= compare makes a lowered presc_i fire at once.
    always_comb begin
        tick_s    = 1'b0;
        pc_next_s = pc_r;
        if (pc_r >= presc_i) begin
            tick_s    = 1'b1;
            pc_next_s = PC_ZERO;
        end else begin
            tick_s    = 1'b0;
            pc_next_s = pc_r + PC_ONE;
        end
    end

    // Prescaler counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_r <= PC_ZERO;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Effective threshold: a programmed zero behaves as one.
    always_comb begin
        thr_s = thresh_i;
        if (thresh_i == CNT_ZERO) begin
            thr_s = CNT_ONE;
        end else begin
            thr_s = thresh_i;
        end
    end

    // Per-pin debounce decision: bypass, count on mismatch, or restart on match.
    always_comb begin
        filt_next_s = filt_r;
        for (int k = 0; k < N_PINS; k++) begin
            cnt_next_s[k] = cnt_r[k];
            cnt_inc_s[k]  = {1'b0, cnt_r[k]} + CNT_ONE_X;
            if (!filt_en_i[k]) begin
                filt_next_s[k] = s2_r[k];
                cnt_next_s[k]  = CNT_ZERO;
            end else if (tick_s) begin
                if (s2_r[k] != filt_r[k]) begin
                    if (cnt_inc_s[k] >= {1'b0, thr_s}) begin
                        filt_next_s[k] = s2_r[k];
                        cnt_next_s[k]  = CNT_ZERO;
                    end else begin
                        cnt_next_s[k]  = cnt_inc_s[k][CNT_W-1:0];
                    end
                end else begin
                    cnt_next_s[k] = CNT_ZERO;
                end
            end else begin
                cnt_next_s[k]  = cnt_r[k];
                filt_next_s[k] = filt_r[k];
            end
        end
    end

    // Stability counters.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < N_PINS; k++) begin
            if (rst_i) begin
                cnt_r[k] <= CNT_ZERO;
            end else begin
                cnt_r[k] <= cnt_next_s[k];
            end
        end
    end

    // Filtered level plus edge pulses aligned with the level change.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_r <= PINS_ZERO;
            rise_r <= PINS_ZERO;
            fall_r <= PINS_ZERO;
        end else begin
            filt_r <= filt_next_s;
            rise_r <= filt_next_s & ~filt_r;
            fall_r <= ~filt_next_s & filt_r;
        end
    end

    // Sticky edge events; a new edge beats a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evt_r <= PINS_ZERO;
        end else begin
            evt_r <= (evt_r & ~evt_clr_i) | rise_r | fall_r;
        end
    end

    assign filt_o = filt_r;
    assign rise_o = rise_r;
    assign fall_o = fall_r;
    assign evt_o  = evt_r;
    assign irq_o  = |(evt_r & irq_mask_i);

endmodule

// File: tb/tb_pad_input_filter.sv
// Self-checking bench for pad_input_filter: a hand-derived bypass vector
// table, directed multi-cycle corner cases, and a randomized run compared
// against a behavioural model of the filter rules.
module tb_pad_input_filter;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  pad = '0;
    logic [N-1:0]  en = '0;
    logic [15:0]   presc = '0;
    logic [7:0]    thresh = '0;
    logic [N-1:0]  mask = '0;
    logic [N-1:0]  clr = '0;
    logic [N-1:0]  filt, rise, fall, evt;
    logic          irq;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // behavioural model state
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_filt = '0, m_rise = '0, m_fall = '0, m_evt = '0;
    int m_pc = 0;
    int m_cnt [N];

    pad_input_filter dut (
        .clk_i(clk), .rst_i(rst), .pad_in_i(pad), .filt_en_i(en),
        .presc_i(presc), .thresh_i(thresh), .irq_mask_i(mask), .evt_clr_i(clr),
        .filt_o(filt), .rise_o(rise), .fall_o(fall), .evt_o(evt), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic [N-1:0] nf;
        bit tk;
        int thr;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_filt = '0; m_rise = '0; m_fall = '0; m_evt = '0;
            m_pc = 0;
            for (int k = 0; k < N; k++) m_cnt[k] = 0;
        end else begin
            tk  = (m_pc >= int'(presc));
            thr = (thresh == 8'd0) ? 1 : int'(thresh);
            nf  = m_filt;
            for (int k = 0; k < N; k++) begin
                if (!en[k]) begin
                    nf[k] = m_s2[k];
                    m_cnt[k] = 0;
                end else if (tk) begin
                    if (m_s2[k] != m_filt[k]) begin
                        if (m_cnt[k] + 1 >= thr) begin
                            nf[k] = m_s2[k];
                            m_cnt[k] = 0;
                        end else begin
                            m_cnt[k] = m_cnt[k] + 1;
                        end
                    end else begin
                        m_cnt[k] = 0;
                    end
                end
            end
            m_evt  = (m_evt & ~clr) | m_rise | m_fall;
            m_rise = nf & ~m_filt;
            m_fall = ~nf & m_filt;
            m_filt = nf;
            m_pc   = tk ? 0 : m_pc + 1;
            m_s2   = m_s1;
            m_s1   = pad;
        end
    endtask

    // One clock: update the model at the edge, then compare just after it.
    task automatic step();
        logic [N*4:0] got, exp;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        got = {filt, rise, fall, evt, irq};
        exp = {m_filt, m_rise, m_fall, m_evt, |(m_evt & mask)};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL model cycle=%0d filt=%h/%h rise=%h/%h fall=%h/%h evt=%h/%h irq=%b/%b",
                     cyc, filt, m_filt, rise, m_rise, fall, m_fall, evt, m_evt, irq, |(m_evt & mask));
        end
    endtask

    typedef struct {
        logic pad3;
        logic clr3;
        logic f;
        logic r;
        logic fl;
        logic e;
        logic q;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int n, hi, nr, nfl;
        bit seen;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;

        // table: pad3, clr3, filt3, rise3, fall3, evt3, irq (checked after the edge)
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // reset
        rst = 1'b1;
        step(); step();
        chk("reset_outputs", {filt, rise, fall, evt, irq}, '0);
        rst = 1'b0;

        // bypass vectors on pin 3
        en = '0; mask = 32'h0000_0008;
        for (int i = 0; i < 10; i++) begin
            pad[3] = tbl[i].pad3;
            clr[3] = tbl[i].clr3;
            step();
            chk($sformatf("bypass_row%0d", i),
                {filt[3], rise[3], fall[3], evt[3], irq},
                {tbl[i].f, tbl[i].r, tbl[i].fl, tbl[i].e, tbl[i].q});
        end
        clr = '0;

        // glitch rejection: 3-cycle pulse with thresh 4
        en = '1; presc = 16'd0; thresh = 8'd4; mask = '0;
        step();
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            pad[0] = (i < 3);
            step();
            if (filt[0] || rise[0]) seen = 1'b1;
        end
        chk("glitch3_rejected", 64'(seen), 64'd0);

        // 4-cycle pulse passes for exactly 4 cycles
        hi = 0; nr = 0; nfl = 0;
        for (int i = 0; i < 16; i++) begin
            pad[0] = (i < 4);
            step();
            hi += int'(filt[0]); nr += int'(rise[0]); nfl += int'(fall[0]);
        end
        chk("glitch4_high_cycles", 64'(hi), 64'd4);
        chk("glitch4_rises", 64'(nr), 64'd1);
        chk("glitch4_falls", 64'(nfl), 64'd1);

        // thresh 0 behaves as 1: latency of 3 edges both directions
        thresh = 8'd0;
        step();
        pad[1] = 1'b1;
        n = 0;
        do begin step(); n++; end while (!filt[1] && n < 10);
        chk("thresh0_rise_latency", 64'(n), 64'd3);
        thresh = 8'd1;
        pad[1] = 1'b0;
        n = 0;
        do begin step(); n++; end while (filt[1] && n < 10);
        chk("thresh1_fall_latency", 64'(n), 64'd3);

        // prescaler latency window with presc 9, thresh 2
        presc = 16'd9; thresh = 8'd2;
        step(); step(); step();
        pad[5] = 1'b1;
        n = 0;
        do begin step(); n++; end while (!filt[5] && n < 40);
        chk("presc_latency_in_window", 64'((n >= 13) && (n <= 22)), 64'd1);

        // tick period
        n = 0;
        while (dut.tick_s !== 1'b1 && n < 30) begin step(); n++; end
        n = 0;
        do begin step(); n++; end while (dut.tick_s !== 1'b1 && n < 30);
        chk("tick_period", 64'(n), 64'd10);

        // lowering presc below pc fires a tick immediately
        n = 0;
        while (dut.pc_r !== 16'd7 && n < 30) begin step(); n++; end
        chk("reached_pc7", 64'(dut.pc_r), 64'd7);
        presc = 16'd2;
        #1;
        chk("presc_lowered_tick", 64'(dut.tick_s), 64'd1);
        step();
        presc = 16'd0;
        step(); step();

        // event clear race on pin 7 (bypass)
        en = ~32'h0000_0080; mask = 32'h0000_0080;
        pad[7] = 1'b1;
        n = 0;
        do begin step(); n++; end while (!rise[7] && n < 10);
        chk("race_rise_seen", 64'(rise[7]), 64'd1);
        clr = 32'h0000_0080;
        step();
        clr = '0;
        chk("race_set_wins", 64'(evt[7]), 64'd1);
        step();
        clr = '1;
        step();
        clr = '0;
        chk("clear_evt7", 64'(evt[7]), 64'd0);
        chk("clear_irq", 64'(irq), 64'd0);

        // lowering thresh 8 -> 2 while cnt is 5 on pin 2
        en = '1; presc = 16'd0; thresh = 8'd8; mask = '1;
        pad[2] = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("thr_cnt5_not_flipped", 64'(filt[2]), 64'd0);
        thresh = 8'd2;
        step();
        chk("thr_lowered_flip", 64'(filt[2]), 64'd1);
        step(); step();

        // reset while cnt[2]=3 and evt nonzero
        thresh = 8'd8;
        pad[2] = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("pre_reset_evt_nonzero", 64'(evt != '0), 64'd1);
        rst = 1'b1;
        pad[2] = 1'b1;
        step();
        rst = 1'b0;
        chk("midreset_outputs", {filt, rise, fall, evt, irq}, '0);
        nr = 0; n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (rise[2]) begin
                nr++;
                if (n == 0) n = i;
            end
        end
        chk("post_reset_single_rise", 64'(nr), 64'd1);
        chk("post_reset_rise_latency", 64'(n), 64'd10);

        // randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            if (i % 50 == 0) begin
                en     = $urandom;
                presc  = 16'($urandom_range(0, 3));
                thresh = 8'($urandom_range(0, 3));
                mask   = $urandom;
            end
            pad = pad ^ ($urandom & $urandom & $urandom);
            clr = $urandom & $urandom;
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
